// File: rtl/edg_generator.sv
// Edge-pattern generator: buffers rise/fall commands in a FIFO and replays them on a registered level.
// Optional macro EDG_GEN_ERR_EN builds the sticky redundant-command flag (err tied low otherwise).
module edg_generator #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic        INIT_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_hold,
  output logic             signal,
  output logic             pedge,
  output logic             nedge,
  output logic             busy,
  output logic             err
);

  localparam int unsigned    PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = FIFO_DEPTH[PTR_W:0];

  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_e;

  logic             mem_dir_r  [FIFO_DEPTH];
  logic [CNT_W-1:0] mem_hold_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [PTR_W:0]   count_r, count_nx_s;
  state_e           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             signal_r, pedge_r, nedge_r, busy_r, ready_r;
  logic             push_s, pop_s, head_dir_s;
  logic [CNT_W-1:0] head_hold_s, load_s;

  assign push_s      = cmd_valid && ready_r;
  assign pop_s       = (state_r == IDLE) && (count_r != '0);
  assign head_dir_s  = mem_dir_r[rd_ptr_r];
  assign head_hold_s = mem_hold_r[rd_ptr_r];
  // A zero hold behaves as one, so the loaded count can never wrap below zero.
  assign load_s      = (head_hold_s == '0) ? '0 : (head_hold_s - CNT_W'(1'b1));

  // Next occupancy from push/pop.
  always_comb begin
    count_nx_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nx_s = count_r + (PTR_W+1)'(1'b1);
      2'b01:   count_nx_s = count_r - (PTR_W+1)'(1'b1);
      default: count_nx_s = count_r;
    endcase
  end

  // FIFO storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_dir_r[i]  <= 1'b0;
        mem_hold_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_dir_r[wr_ptr_r]  <= cmd_dir;
      mem_hold_r[wr_ptr_r] <= cmd_hold;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      else        wr_ptr_r <= wr_ptr_r;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      else        rd_ptr_r <= rd_ptr_r;
      count_r <= count_nx_s;
    end
  end

  // Edge FSM with registered level, pulses, busy and ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      signal_r <= INIT_LEVEL;
      pedge_r  <= 1'b0;
      nedge_r  <= 1'b0;
      busy_r   <= 1'b0;
      ready_r  <= 1'b0;
    end else begin
      pedge_r <= 1'b0;
      nedge_r <= 1'b0;
      ready_r <= (count_nx_s != FULL_CNT);
      busy_r  <= (count_nx_s != '0);
      case (state_r)
        IDLE: begin
          if (pop_s && (head_dir_s != signal_r)) begin
            signal_r <= head_dir_s;
            pedge_r  <= head_dir_s;
            nedge_r  <= ~head_dir_s;
            cnt_r    <= load_s;
            if (load_s != '0) begin
              state_r <= HOLD;
              busy_r  <= 1'b1;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        HOLD: begin
          if (cnt_r <= CNT_W'(1'b1)) begin
            cnt_r   <= '0;
            state_r <= IDLE;
          end else begin
            cnt_r   <= cnt_r - CNT_W'(1'b1);
            state_r <= HOLD;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          cnt_r   <= '0;
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef EDG_GEN_ERR_EN
  logic err_r, redundant_s;
  assign redundant_s = pop_s && (head_dir_s == signal_r);

  // Sticky flag for a popped command that asks for the level already driven.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             err_r <= 1'b0;
    else if (redundant_s) err_r <= 1'b1;
    else                  err_r <= err_r;
  end
  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign cmd_ready = ready_r;
  assign signal    = signal_r;
  assign pedge     = pedge_r;
  assign nedge     = nedge_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_edg_generator.sv
// Directed self-checking bench for edg_generator (CNT_W=8, FIFO_DEPTH=4, INIT_LEVEL=0).
module tb_edg_generator;

`ifdef EDG_GEN_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, cmd_valid, cmd_ready, cmd_dir;
  logic [7:0] cmd_hold;
  logic       signal, pedge, nedge, busy, err;
  int         nvec = 0;
  int         nerr = 0;
  logic       exp_dir;

  edg_generator #(.CNT_W(8), .FIFO_DEPTH(4), .INIT_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_hold(cmd_hold), .signal(signal),
    .pedge(pedge), .nedge(nedge), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic s, input logic p, input logic n);
    chk({tag, ".signal"}, signal, s);
    chk({tag, ".pedge"},  pedge,  p);
    chk({tag, ".nedge"},  nedge,  n);
  endtask

  task automatic send(input logic d, input logic [7:0] h);
    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_hold  = h;
  endtask

  task automatic idle_in();
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_hold  = 8'd0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("rst.ready", cmd_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b0;
    send(1'b1, 8'd3);
    step();
    step();
    // reset state while valid is asserted
    chk_out("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.ready", cmd_ready, 1'b0);
    chk("reset.busy",  busy,      1'b0);
    chk("reset.err",   err,       1'b0);
    rst = 1'b1;
    step();
    chk("release.ready", cmd_ready, 1'b1);
    chk("release.busy",  busy,      1'b0);
    chk("release.signal", signal,   1'b0);
    idle_in();
    step();

    // single rise, hold 3
    send(1'b1, 8'd3);
    step();
    chk_out("rise.t0", 1'b0, 1'b0, 1'b0);
    idle_in();
    step();
    chk_out("rise.t1", 1'b1, 1'b1, 1'b0);
    chk("rise.t1.busy", busy, 1'b1);
    step();
    chk_out("rise.t2", 1'b1, 1'b0, 1'b0);
    chk("rise.t2.busy", busy, 1'b1);
    step();
    step();
    chk_out("rise.t4", 1'b1, 1'b0, 1'b0);
    chk("rise.t4.busy", busy, 1'b0);

    // burst: edges at t+1, t+3, t+8, then fill the FIFO during the long hold
    do_reset();
    send(1'b1, 8'd2);
    step();
    send(1'b0, 8'd5);
    step();
    chk_out("burst.t1", 1'b1, 1'b1, 1'b0);
    send(1'b1, 8'd0);
    step();
    chk_out("burst.t2", 1'b1, 1'b0, 1'b0);
    send(1'b0, 8'd1);
    step();
    chk_out("burst.t3", 1'b0, 1'b0, 1'b1);
    send(1'b1, 8'd1);
    step();
    chk_out("burst.t4", 1'b0, 1'b0, 1'b0);
    chk("burst.t4.ready", cmd_ready, 1'b1);
    send(1'b0, 8'd1);
    step();
    chk("burst.t5.ready", cmd_ready, 1'b0);
    chk("burst.t5.busy",  busy,      1'b1);
    send(1'b1, 8'd9);
    step();
    chk("burst.t6.ready", cmd_ready, 1'b0);
    chk_out("burst.t6", 1'b0, 1'b0, 1'b0);
    step();
    chk("burst.t7.ready", cmd_ready, 1'b0);
    chk_out("burst.t7", 1'b0, 1'b0, 1'b0);
    step();
    chk_out("burst.t8", 1'b1, 1'b1, 1'b0);
    chk("burst.t8.ready", cmd_ready, 1'b1);
    idle_in();
    step();
    chk_out("burst.t9", 1'b0, 1'b0, 1'b1);
    step();
    chk_out("burst.t10", 1'b1, 1'b1, 1'b0);
    step();
    chk_out("burst.t11", 1'b0, 1'b0, 1'b1);
    step();
    chk_out("burst.t12", 1'b0, 1'b0, 1'b0);
    chk("burst.t12.busy", busy, 1'b0);

    // redundant command followed by a rise
    do_reset();
    chk("redund.err0", err, 1'b0);
    send(1'b0, 8'd4);
    step();
    send(1'b1, 8'd1);
    step();
    chk_out("redund.t1", 1'b0, 1'b0, 1'b0);
    chk("redund.t1.err", err, ERR_ON);
    idle_in();
    step();
    chk_out("redund.t2", 1'b1, 1'b1, 1'b0);
    chk("redund.t2.err", err, ERR_ON);
    step();
    chk_out("redund.t3", 1'b1, 1'b0, 1'b0);
    chk("redund.t3.busy", busy, 1'b0);

    // wrap-around: 10 alternating hold-1 commands, one edge per cycle
    do_reset();
    for (int k = 0; k < 10; k++) begin
      send((k % 2 == 0) ? 1'b1 : 1'b0, 8'd1);
      step();
      if (k > 0) begin
        exp_dir = ((k - 1) % 2 == 0) ? 1'b1 : 1'b0;
        chk_out($sformatf("wrap.%0d", k - 1), exp_dir, exp_dir, ~exp_dir);
      end
    end
    idle_in();
    step();
    chk_out("wrap.9", 1'b0, 1'b0, 1'b1);
    step();
    chk_out("wrap.end", 1'b0, 1'b0, 1'b0);
    chk("wrap.end.busy", busy, 1'b0);

    // reset two cycles into a hold of 6 with two commands queued
    do_reset();
    send(1'b1, 8'd6);
    step();
    send(1'b0, 8'd1);
    step();
    chk_out("rsthold.t1", 1'b1, 1'b1, 1'b0);
    send(1'b1, 8'd1);
    step();
    idle_in();
    chk("rsthold.t2.busy", busy, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk_out("rsthold.async", 1'b0, 1'b0, 1'b0);
    chk("rsthold.async.busy",  busy,      1'b0);
    chk("rsthold.async.ready", cmd_ready, 1'b0);
    step();
    rst = 1'b1;
    step();
    chk("rsthold.release.ready", cmd_ready, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("rsthold.quiet%0d", k), signal | pedge | nedge | busy, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
